pla_exep_hit_scanner: RTL and testbench

- Downstream consumer of the exep decode plane.
- Captures one 63-bit decoded output vector (z00..z62) per valid/ready transaction.
- Serialises the indices of all asserted bits, lowest index first, one per cycle, on a valid/ready stream, so the sequencer can dispatch one action per hit.
- Emits exactly one "empty" beat when no bits are set, and keeps a frame counter for status.

---
 rtl/pla_exep_hit_scanner_if.sv | 26 ++
 rtl/pla_exep_hit_scanner.sv | 117 +++++++++++
 tb/tb_pla_exep_hit_scanner.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pla_exep_hit_scanner_if.sv
// Snapshot-in / hit-index-out stream bundle for the exep hit scanner.
// master: the side that supplies snapshots and consumes beats; slave: the scanner.
interface pla_exep_hit_scanner_if #(
    parameter int unsigned W     = 63,
    parameter int unsigned IDX_W = 6
);
    logic [W-1:0]     in_vec;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic [IDX_W:0]   out_ord;
    logic             out_last;
    logic             out_empty;

    modport master (
        output in_vec, in_valid, out_ready,
        input  in_ready, out_valid, out_idx, out_ord, out_last, out_empty
    );

    modport slave (
        input  in_vec, in_valid, out_ready,
        output in_ready, out_valid, out_idx, out_ord, out_last, out_empty
    );
endinterface

// File: rtl/pla_exep_hit_scanner.sv
// Captures one decoded exep vector per handshake and streams the indices of its set bits,
// lowest first, one beat per cycle; an all-clear vector yields a single "empty" beat.
module pla_exep_hit_scanner #(
    parameter int unsigned   W           = 63,
    parameter int unsigned   IDX_W       = 6,
    parameter logic [W-1:0]  IGNORE_MASK = '0,
    parameter int unsigned   CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pla_exep_hit_scanner_if.slave       bus,
    output logic [CNT_W-1:0]            frame_cnt
);

    localparam logic [W-1:0]     VEC_ONE = 1;
    localparam logic [IDX_W:0]   ORD_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic [0:0] {StIdle, StEmit} state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     rem_q, rem_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W:0]   ord_q, ord_d;
    logic             last_q, last_d;
    logic             empty_q, empty_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             beat_fire;
    logic             frame_done;
    logic             capture;
    logic [W-1:0]     snap;
    logic [W-1:0]     scan_src;
    logic [W-1:0]     scan_rest;
    logic [IDX_W-1:0] scan_idx;

    // Priority encoder: index of the lowest set bit, 0 when none is set.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [W-1:0] v);
        lowest_set = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = IDX_W'(i);
        end
    endfunction

    assign beat_fire  = (state_q == StEmit) & bus.out_ready;
    assign frame_done = beat_fire & last_q;
    // out_ready feeds in_ready combinationally so a new frame can follow the last beat directly.
    assign bus.in_ready = rst_n & ((state_q == StIdle) | frame_done);
    assign capture      = bus.in_valid & bus.in_ready;
    assign snap         = bus.in_vec & ~IGNORE_MASK;

    // Capture and advance never coincide, so one encoder serves both.
    assign scan_src  = capture ? snap : rem_q;
    assign scan_idx  = lowest_set(scan_src);
    assign scan_rest = scan_src & (scan_src - VEC_ONE);

    // Next-state: advance within the frame, close it on the last beat, or load a new snapshot.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        ord_d   = ord_q;
        last_d  = last_q;
        empty_d = empty_q;
        cnt_d   = cnt_q;

        if (beat_fire) begin
            if (last_q) begin
                cnt_d   = cnt_q + CNT_ONE;
                state_d = StIdle;
            end else begin
                idx_d  = scan_idx;
                rem_d  = scan_rest;
                ord_d  = ord_q + ORD_ONE;
                last_d = (scan_rest == '0);
            end
        end

        if (capture) begin
            state_d = StEmit;
            idx_d   = scan_idx;
            rem_d   = scan_rest;
            empty_d = (snap == '0);
            ord_d   = (snap == '0) ? '0 : ORD_ONE;
            last_d  = (scan_rest == '0);
        end
    end

    // State and beat registers; synchronous reset drops any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rem_q   <= '0;
            idx_q   <= '0;
            ord_q   <= '0;
            last_q  <= 1'b0;
            empty_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            ord_q   <= ord_d;
            last_q  <= last_d;
            empty_q <= empty_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.out_valid = (state_q == StEmit);
    assign bus.out_idx   = idx_q;
    assign bus.out_ord   = ord_q;
    assign bus.out_last  = last_q;
    assign bus.out_empty = empty_q;
    assign frame_cnt     = cnt_q;

endmodule

// File: tb/tb_pla_exep_hit_scanner.sv
// Scoreboard bench for pla_exep_hit_scanner: the driver queues the expected beats of each
// captured frame, the monitor pops and compares every cycle a beat is presented.
module tb_pla_exep_hit_scanner;

    localparam logic [62:0] MASK2 = 63'h1 << 62;

    typedef struct {
        logic [5:0] idx;
        logic [6:0] ord;
        logic       last;
        logic       empty;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] frame_cnt;
    logic [1:0]  frame_cnt2;

    pla_exep_hit_scanner_if #(.W(63), .IDX_W(6)) bus ();
    pla_exep_hit_scanner_if #(.W(63), .IDX_W(6)) bus2 ();

    pla_exep_hit_scanner dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .frame_cnt (frame_cnt)
    );

    pla_exep_hit_scanner #(
        .IGNORE_MASK (MASK2),
        .CNT_W       (2)
    ) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus2),
        .frame_cnt (frame_cnt2)
    );

    beat_t       q[$];
    logic [15:0] exp_cnt;
    int          total;
    int          bad;
    int          rdy_mode;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: beats are the unmasked set bits in ascending order, or one empty beat.
    task automatic push_frame(input logic [62:0] vec, input logic [62:0] mask);
        logic [62:0] v;
        int          n;
        int          ord;
        beat_t       b;
        v   = vec & ~mask;
        n   = $countones(v);
        ord = 0;
        if (n == 0) begin
            b.idx = 0; b.ord = 0; b.last = 1'b1; b.empty = 1'b1;
            q.push_back(b);
        end else begin
            for (int i = 0; i < 63; i++) begin
                if (v[i]) begin
                    ord++;
                    b.idx = 6'(i); b.ord = 7'(ord); b.last = (ord == n); b.empty = 1'b0;
                    q.push_back(b);
                end
            end
        end
    endtask

    task automatic sync();
        @(negedge clk);
        #2;
    endtask

    // Called at negedge+2; returns at negedge+2 of the cycle after capture.
    task automatic send(input logic [62:0] vec);
        int n;
        logic [63:0] r;
        n = 0;
        bus.in_vec   = vec;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk("capture_timeout", {63'h0, bus.in_ready}, 64'h1);
        if (bus.in_ready) push_frame(vec, 63'h0);
        @(negedge clk);
        #2;
        bus.in_valid = 1'b0;
        r = {$urandom(), $urandom()};
        bus.in_vec = r[62:0];
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(q.size()), 64'h0);
        sync();
    endtask

    // out_ready driver: 0 = always ready, 1 = random, 2 = stalled.
    initial begin
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom() % 4) != 0;
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compares the presented beat against the scoreboard head every cycle.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                chk("frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
                chk("out_valid", {63'h0, bus.out_valid}, {63'h0, q.size() != 0});
                chk("in_ready", {63'h0, bus.in_ready},
                    {63'h0, (q.size() == 0) || (bus.out_ready && q[0].last)});
                if (bus.out_valid && q.size() != 0) begin
                    chk("idx", 64'(bus.out_idx), 64'(q[0].idx));
                    chk("ord", 64'(bus.out_ord), 64'(q[0].ord));
                    chk("last", {63'h0, bus.out_last}, {63'h0, q[0].last});
                    chk("empty", {63'h0, bus.out_empty}, {63'h0, q[0].empty});
                    if (bus.out_ready) begin
                        if (q[0].last) exp_cnt = exp_cnt + 16'd1;
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        logic [62:0] vec;
        total          = 0;
        bad            = 0;
        exp_cnt        = '0;
        rdy_mode       = 0;
        rst_n          = 1'b0;
        bus.in_vec     = '0;
        bus.in_valid   = 1'b1;
        bus.out_ready  = 1'b1;
        bus2.in_vec    = '0;
        bus2.in_valid  = 1'b0;
        bus2.out_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
        chk("rst_idx", 64'(bus.out_idx), 64'h0);
        chk("rst_ord", 64'(bus.out_ord), 64'h0);
        chk("rst_last", {63'h0, bus.out_last}, 64'h0);
        chk("rst_empty", {63'h0, bus.out_empty}, 64'h0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'h0);
        chk("rst_in_ready", {63'h0, bus.in_ready}, 64'h0);
        bus.in_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        sync();

        // Single bit, multi-bit with both ends, empty
        send(63'h1 << 5);
        drain();
        send((63'h1 << 0) | (63'h1 << 17) | (63'h1 << 62));
        drain();
        send(63'h0);
        drain();

        // Backpressure: first beat held for several cycles
        rdy_mode = 2;
        send((63'h1 << 3) | (63'h1 << 4));
        repeat (5) sync();
        rdy_mode = 0;
        drain();

        // Back-to-back frames with no bubble
        send(63'h1 << 9);
        send((63'h1 << 10) | (63'h1 << 11));
        drain();

        // Randomized frames under random backpressure
        rdy_mode = 1;
        for (int k = 0; k < 40; k++) begin
            r = {$urandom(), $urandom()};
            case ($urandom() % 4)
                0: vec = 63'h0;
                1: vec = 63'h1 << ($urandom() % 63);
                2: vec = r[62:0] & 63'({$urandom(), $urandom()}) & 63'({$urandom(), $urandom()});
                default: vec = r[62:0];
            endcase
            send(vec);
            if ($urandom() % 3 == 0) repeat ($urandom() % 4) sync();
        end
        drain();

        // Reset mid-frame: remaining beats are dropped and nothing follows
        rdy_mode = 0;
        send((63'h1 << 1) | (63'h1 << 2) | (63'h1 << 3));
        rst_n = 1'b0;
        q.delete();
        exp_cnt = '0;
        repeat (2) sync();
        chk("midrst_out_valid", {63'h0, bus.out_valid}, 64'h0);
        chk("midrst_frame_cnt", 64'(frame_cnt), 64'h0);
        rst_n = 1'b1;
        repeat (4) sync();

        // Masked-only vector gives an empty beat; small counter wraps after 5 frames
        bus2.in_vec   = 63'h1 << 62;
        bus2.in_valid = 1'b1;
        #1;
        chk("m_in_ready", {63'h0, bus2.in_ready}, 64'h1);
        @(negedge clk);
        #1;
        chk("m_out_valid", {63'h0, bus2.out_valid}, 64'h1);
        chk("m_idx", 64'(bus2.out_idx), 64'h0);
        chk("m_ord", 64'(bus2.out_ord), 64'h0);
        chk("m_last", {63'h0, bus2.out_last}, 64'h1);
        chk("m_empty", {63'h0, bus2.out_empty}, 64'h1);
        #1;
        for (int k = 0; k < 4; k++) begin
            bus2.in_vec = 63'h1 << ($urandom() % 62);
            sync();
        end
        bus2.in_valid = 1'b0;
        repeat (3) sync();
        chk("wrap_frame_cnt", 64'(frame_cnt2), 64'h1);
        chk("wrap_out_valid", {63'h0, bus2.out_valid}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
